powerup_manager: RTL and testbench

Parametrised game-logic block that owns N powerup slots and tracks timed effects for P players. Each cycle it checks every player sprite against every armed powerup for overlap. On pickup it parks the powerup and starts a tick-based effect timer for that (player, powerup) pair. It exposes slot positions and per-player effect masks through a registered memory-mapped read port beside the processor's dmem path.

---
 rtl/powerup_manager_if.sv | 38 +++
 rtl/powerup_manager.sv | 189 ++++++++++++++++++
 tb/tb_powerup_manager.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/powerup_manager_if.sv
// Bus bundle for powerup_manager: player positions, spawn
// requests, dmem read port and slot/effect status outputs.
interface powerup_manager_if #(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_POWERUPS = 2,
  parameter int COORD_W      = 32
);
  localparam int ID_W = (NUM_POWERUPS > 1) ?
    $clog2(NUM_POWERUPS) : 1;

  logic [NUM_PLAYERS*COORD_W-1:0]  player_x;
  logic [NUM_PLAYERS*COORD_W-1:0]  player_y;
  logic                            spawn_valid;
  logic [ID_W-1:0]                 spawn_id;
  logic [COORD_W-1:0]              spawn_x;
  logic [COORD_W-1:0]              spawn_y;
  logic [16:0]                     address_dmem;
  logic [31:0]                     rd_data;
  logic                            rd_hit;
  logic [NUM_POWERUPS*COORD_W-1:0] powerup_x;
  logic [NUM_POWERUPS*COORD_W-1:0] powerup_y;
  logic [NUM_POWERUPS-1:0]         powerup_armed;
  logic [NUM_PLAYERS*NUM_POWERUPS-1:0] effect_active;

  modport master (
    output player_x, player_y, spawn_valid, spawn_id,
    output spawn_x, spawn_y, address_dmem,
    input  rd_data, rd_hit, powerup_x, powerup_y,
    input  powerup_armed, effect_active
  );

  modport slave (
    input  player_x, player_y, spawn_valid, spawn_id,
    input  spawn_x, spawn_y, address_dmem,
    output rd_data, rd_hit, powerup_x, powerup_y,
    output powerup_armed, effect_active
  );
endinterface

// File: rtl/powerup_manager.sv
// Powerup slots, player pickup detection, timed per-player
// effects and a registered memory-mapped status read port.
module powerup_manager #(
  parameter int NUM_PLAYERS    = 2,
  parameter int NUM_POWERUPS   = 2,
  parameter int COORD_W        = 32,
  parameter int SPRITE_W       = 28,
  parameter int SPRITE_H       = 28,
  parameter int TICK_CYCLES    = 100000000,
  parameter int DURATION_TICKS = 8,
  parameter int BASE_ADDR      = 4300
) (
  input logic clock,
  input logic reset,
  powerup_manager_if.slave bus
);
  localparam int NP     = NUM_PLAYERS;
  localparam int NK     = NUM_POWERUPS;
  localparam int CW     = COORD_W;
  localparam int CW1    = CW + 1;
  localparam int NPK    = NP * NK;
  localparam int ID_W   = (NK > 1) ? $clog2(NK) : 1;
  localparam int PRE_W  = (TICK_CYCLES > 1) ?
    $clog2(TICK_CYCLES) : 1;
  localparam int TICK_W = $clog2(DURATION_TICKS + 1);

  typedef enum logic {
    S_PARKED,
    S_ARMED
  } slot_t;

  slot_t             r_state [NK];
  logic [CW-1:0]     r_ux    [NK];
  logic [CW-1:0]     r_uy    [NK];
  logic [NPK-1:0]    r_eff;
  logic [PRE_W-1:0]  r_pre   [NPK];
  logic [TICK_W-1:0] r_tick  [NPK];
  logic [31:0]       r_rd_data;
  logic              r_rd_hit;

  logic [NK-1:0]  w_armed;
  logic [NK-1:0]  w_spawn;
  logic [NK-1:0]  w_pick;
  logic [NPK-1:0] w_hit;
  logic [NPK-1:0] w_grant;
  logic [16:0]    w_off;
  logic           w_in;
  logic [31:0]    w_data;

  always_comb begin
    for (int k = 0; k < NK; k++) begin
      w_armed[k] = (r_state[k] == S_ARMED);
      w_spawn[k] = bus.spawn_valid &&
                   (bus.spawn_id == ID_W'(k));
    end
  end

  // Widened by one bit so sprite extents never wrap.
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < NK; k++) begin
        w_hit[p*NK+k] = (r_state[k] == S_ARMED) &&
          ({1'b0, bus.player_x[p*CW +: CW]} <=
           {1'b0, r_ux[k]} + CW1'(SPRITE_W)) &&
          ({1'b0, bus.player_x[p*CW +: CW]} +
           CW1'(SPRITE_W) >= {1'b0, r_ux[k]}) &&
          ({1'b0, bus.player_y[p*CW +: CW]} <=
           {1'b0, r_uy[k]} + CW1'(SPRITE_H)) &&
          ({1'b0, bus.player_y[p*CW +: CW]} +
           CW1'(SPRITE_H) >= {1'b0, r_uy[k]});
      end
    end
  end

  // Lowest-index overlapping player takes the slot.
  always_comb begin
    w_grant = w_hit;
    w_pick  = '0;
    for (int k = 0; k < NK; k++) begin
      for (int p = 0; p < NP; p++) begin
        w_pick[k] = w_pick[k] | w_hit[p*NK+k];
        for (int q = 0; q < NP; q++) begin
          if (q < p && w_hit[q*NK+k])
            w_grant[p*NK+k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NK; k++) begin
        r_state[k] <= S_PARKED;
        r_ux[k]    <= '1;
        r_uy[k]    <= '1;
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        unique case (r_state[k])
          S_PARKED: begin
            if (w_spawn[k]) begin
              r_state[k] <= S_ARMED;
              r_ux[k]    <= bus.spawn_x;
              r_uy[k]    <= bus.spawn_y;
            end
          end
          S_ARMED: begin
            if (w_pick[k]) begin
              r_state[k] <= S_PARKED;
            end else if (w_spawn[k]) begin
              r_ux[k] <= bus.spawn_x;
              r_uy[k] <= bus.spawn_y;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_eff <= '0;
      for (int i = 0; i < NPK; i++) begin
        r_pre[i]  <= '0;
        r_tick[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPK; i++) begin
        if (w_grant[i]) begin
          r_eff[i]  <= 1'b1;
          r_pre[i]  <= '0;
          r_tick[i] <= '0;
        end else if (r_eff[i]) begin
          if (r_pre[i] == PRE_W'(TICK_CYCLES - 1)) begin
            r_pre[i] <= '0;
            if (r_tick[i] ==
                TICK_W'(DURATION_TICKS - 1)) begin
              r_eff[i]  <= 1'b0;
              r_tick[i] <= '0;
            end else begin
              r_tick[i] <= r_tick[i] + TICK_W'(1);
            end
          end else begin
            r_pre[i] <= r_pre[i] + PRE_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    w_off  = bus.address_dmem - 17'(BASE_ADDR);
    w_in   = (bus.address_dmem >= 17'(BASE_ADDR)) &&
             (w_off < 17'(2*NK + NP));
    w_data = '0;
    for (int k = 0; k < NK; k++) begin
      if (w_off == 17'(2*k))
        w_data = 32'(bus.powerup_x[k*CW +: CW]);
      if (w_off == 17'(2*k + 1))
        w_data = 32'(bus.powerup_y[k*CW +: CW]);
    end
    for (int p = 0; p < NP; p++) begin
      if (w_off == 17'(2*NK + p))
        w_data = 32'(r_eff[p*NK +: NK]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_data <= '0;
      r_rd_hit  <= 1'b0;
    end else begin
      r_rd_hit  <= w_in;
      r_rd_data <= w_in ? w_data : '0;
    end
  end

  for (genvar k = 0; k < NK; k++) begin : g_out
    assign bus.powerup_x[k*CW +: CW] =
      w_armed[k] ? r_ux[k] : '1;
    assign bus.powerup_y[k*CW +: CW] =
      w_armed[k] ? r_uy[k] : '1;
  end

  assign bus.powerup_armed = w_armed;
  assign bus.effect_active = r_eff;
  assign bus.rd_data       = r_rd_data;
  assign bus.rd_hit        = r_rd_hit;
endmodule

// File: tb/tb_powerup_manager.sv
// Bench for powerup_manager: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_powerup_manager;
  localparam int NP = 2;
  localparam int NK = 2;
  localparam int CW = 32;
  localparam int TC = 4;
  localparam int DT = 3;
  localparam int BA = 4300;
  localparam int SW = 28;
  localparam int SH = 28;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  powerup_manager_if #(
    .NUM_PLAYERS(NP), .NUM_POWERUPS(NK), .COORD_W(CW)
  ) bus ();

  powerup_manager #(
    .NUM_PLAYERS(NP), .NUM_POWERUPS(NK), .COORD_W(CW),
    .SPRITE_W(SW), .SPRITE_H(SH), .TICK_CYCLES(TC),
    .DURATION_TICKS(DT), .BASE_ADDR(BA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  bit          m_ok = 1'b0;
  bit          m_arm [NK];
  logic [31:0] m_x   [NK];
  logic [31:0] m_y   [NK];
  int          m_rem [NP][NK];
  logic [31:0] m_rd;
  bit          m_hit;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic bit overlap(input logic [31:0] px,
                                 input logic [31:0] py,
                                 input logic [31:0] ux,
                                 input logic [31:0] uy);
    longint a, b, c, d;
    a = px; b = py; c = ux; d = uy;
    return (a <= c + SW) && (a + SW >= c) &&
           (b <= d + SH) && (b + SH >= d);
  endfunction

  // Effects modelled as a countdown of remaining active cycles.
  task automatic model_step();
    bit     picked [NK];
    longint off;
    int     s;
    if (reset) begin
      for (int k = 0; k < NK; k++) m_arm[k] = 1'b0;
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < NK; k++) m_rem[p][k] = 0;
      m_rd  = '0;
      m_hit = 1'b0;
      m_ok  = 1'b1;
      return;
    end
    off   = longint'(bus.address_dmem) - BA;
    m_rd  = '0;
    m_hit = 1'b0;
    if (off >= 0 && off < 2*NK) begin
      s     = int'(off / 2);
      m_hit = 1'b1;
      if (!m_arm[s]) m_rd = 32'hFFFF_FFFF;
      else m_rd = (off % 2 == 1) ? m_y[s] : m_x[s];
    end else if (off >= 2*NK && off < 2*NK + NP) begin
      s     = int'(off - 2*NK);
      m_hit = 1'b1;
      for (int k = 0; k < NK; k++)
        m_rd[k] = (m_rem[s][k] > 0);
    end
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < NK; k++)
        if (m_rem[p][k] > 0) m_rem[p][k]--;
    for (int k = 0; k < NK; k++) begin
      picked[k] = 1'b0;
      if (m_arm[k]) begin
        for (int p = 0; p < NP; p++) begin
          if (!picked[k] &&
              overlap(bus.player_x[p*CW +: CW],
                      bus.player_y[p*CW +: CW],
                      m_x[k], m_y[k])) begin
            picked[k]   = 1'b1;
            m_rem[p][k] = TC * DT;
            m_arm[k]    = 1'b0;
          end
        end
      end
    end
    s = int'(bus.spawn_id);
    if (bus.spawn_valid && s < NK && !picked[s]) begin
      m_arm[s] = 1'b1;
      m_x[s]   = bus.spawn_x;
      m_y[s]   = bus.spawn_y;
    end
  endtask

  always @(posedge clock) model_step();

  always @(posedge clock) begin
    logic [NK-1:0]    ea;
    logic [NK*CW-1:0] ex, ey;
    logic [NP*NK-1:0] ee;
    #1;
    if (m_ok) begin
      for (int k = 0; k < NK; k++) begin
        ea[k] = m_arm[k];
        ex[k*CW +: CW] = m_arm[k] ? m_x[k] : '1;
        ey[k*CW +: CW] = m_arm[k] ? m_y[k] : '1;
      end
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < NK; k++)
          ee[p*NK+k] = (m_rem[p][k] > 0);
      chk("m_armed", 64'(bus.powerup_armed), 64'(ea));
      chk("m_px", 64'(bus.powerup_x), 64'(ex));
      chk("m_py", 64'(bus.powerup_y), 64'(ey));
      chk("m_eff", 64'(bus.effect_active), 64'(ee));
      chk("m_rd", 64'(bus.rd_data), 64'(m_rd));
      chk("m_hit", 64'(bus.rd_hit), 64'(m_hit));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic place(input int p, input int x, input int y);
    bus.player_x[p*CW +: CW] = 32'(x);
    bus.player_y[p*CW +: CW] = 32'(y);
  endtask

  task automatic spawn(input int k, input int x, input int y);
    bus.spawn_valid = 1'b1;
    bus.spawn_id    = 1'(k);
    bus.spawn_x     = 32'(x);
    bus.spawn_y     = 32'(y);
    tick();
    bus.spawn_valid = 1'b0;
  endtask

  task automatic count_high(input int b, output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.effect_active[b]) n++;
      else break;
    end
  endtask

  function automatic logic [31:0] rcoord();
    if ($urandom_range(0, 19) == 0)
      return 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
    return 32'($urandom_range(0, 300));
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    bus.spawn_valid  = 1'b0;
    bus.spawn_id     = '0;
    bus.spawn_x      = '0;
    bus.spawn_y      = '0;
    bus.address_dmem = '0;
    place(0, 1000, 1000);
    place(1, 2000, 2000);
    tick(); tick();
    reset = 1'b0;
    bus.address_dmem = 17'(BA);
    tick();
    chk("rd_base", 64'(bus.rd_data), 64'hFFFF_FFFF);
    chk("hit_base", 64'(bus.rd_hit), 64'd1);
    chk("armed_rst", 64'(bus.powerup_armed), 64'd0);
    chk("eff_rst", 64'(bus.effect_active), 64'd0);
    bus.address_dmem = 17'(BA + 1);
    tick();
    chk("rd_base1", 64'(bus.rd_data), 64'hFFFF_FFFF);

    spawn(0, 300, 300);
    chk("armed_spawn", 64'(bus.powerup_armed[0]), 64'd1);
    chk("x_spawn", 64'(bus.powerup_x[31:0]), 64'd300);
    place(0, 260, 240);
    tick();
    chk("no_pick", 64'(bus.powerup_armed[0]), 64'd1);
    place(0, 273, 273);
    tick();
    chk("pick_armed", 64'(bus.powerup_armed[0]), 64'd0);
    chk("pick_eff", 64'(bus.effect_active[0]), 64'd1);
    chk("pick_x", 64'(bus.powerup_x[31:0]), 64'hFFFF_FFFF);
    place(0, 1000, 1000);
    count_high(0, n);
    chk("dur_first", 64'(n), 64'd12);

    spawn(0, 300, 300);
    place(0, 300, 300);
    tick();
    chk("pick2_eff", 64'(bus.effect_active[0]), 64'd1);
    place(0, 1000, 1000);
    spawn(0, 300, 300);
    tick(); tick(); tick();
    chk("eff_mid", 64'(bus.effect_active[0]), 64'd1);
    place(0, 300, 300);
    tick();
    place(0, 1000, 1000);
    count_high(0, n);
    chk("dur_repick", 64'(n), 64'd12);

    spawn(1, 500, 500);
    place(0, 500, 500);
    place(1, 510, 490);
    bus.spawn_valid = 1'b1;
    bus.spawn_id    = 1'b1;
    bus.spawn_x     = 32'd600;
    bus.spawn_y     = 32'd600;
    tick();
    bus.spawn_valid = 1'b0;
    place(0, 1000, 1000);
    place(1, 2000, 2000);
    chk("p0k1_win", 64'(bus.effect_active[1]), 64'd1);
    chk("p1k1_lose", 64'(bus.effect_active[3]), 64'd0);
    chk("k1_parked", 64'(bus.powerup_armed[1]), 64'd0);
    tick();
    chk("spawn_dropped", 64'(bus.powerup_armed[1]), 64'd0);

    spawn(0, 100, 100);
    spawn(1, 700, 700);
    place(1, 100, 100);
    tick();
    place(1, 700, 700);
    tick();
    place(1, 2000, 2000);
    bus.address_dmem = 17'(BA + 5);
    tick();
    chk("mask_p1", 64'(bus.rd_data), 64'd3);
    chk("mask_hit", 64'(bus.rd_hit), 64'd1);
    bus.address_dmem = 17'(4299);
    tick();
    chk("below_rd", 64'(bus.rd_data), 64'd0);
    chk("below_hit", 64'(bus.rd_hit), 64'd0);
    bus.address_dmem = 17'(BA + 6);
    tick();
    chk("above_rd", 64'(bus.rd_data), 64'd0);
    chk("above_hit", 64'(bus.rd_hit), 64'd0);
    chk("eff_pre_rst", 64'(bus.effect_active[3:2]), 64'd3);
    reset = 1'b1;
    tick();
    chk("eff_mid_rst", 64'(bus.effect_active), 64'd0);
    chk("armed_mid_rst", 64'(bus.powerup_armed), 64'd0);
    reset = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int p = 0; p < NP; p++) begin
        bus.player_x[p*CW +: CW] = rcoord();
        bus.player_y[p*CW +: CW] = rcoord();
      end
      bus.spawn_valid  = ($urandom_range(0, 3) == 0);
      bus.spawn_id     = 1'($urandom_range(0, 1));
      bus.spawn_x      = rcoord();
      bus.spawn_y      = rcoord();
      bus.address_dmem =
        17'($urandom_range(BA - 4, BA + 8));
      tick();
    end
    reset = 1'b0;
    bus.spawn_valid = 1'b0;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
